// File: rtl/axis_pkt_gen_pkg.sv
// Shared definitions for the AXI4-Stream packet generator: NetFPGA tuser
// field offsets, FSM state encoding and length helpers.
package axis_pkt_gen_pkg;

   localparam int LEN_LSB       = 0;
   localparam int SRC_LSB       = 16;
   localparam int DST_LSB       = 24;
   localparam int C_MIN_LEN_DEF = 60;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Index of the final 32-byte beat for a packet of len bytes (len >= 1).
   function automatic logic [10:0] last_beat_idx(input logic [15:0] len);
      return 11'((len - 16'd1) >> 5);
   endfunction

endpackage

// File: rtl/axis_pkt_gen_pattern.sv
// Deterministic payload and byte-strobe generator for one 256-bit beat.
module axis_pkt_gen_pattern
   import axis_pkt_gen_pkg::*;
(
   input  logic [15:0]  i_seq,
   input  logic [7:0]   i_beat,
   input  logic         i_last,
   input  logic [4:0]   i_len_rem,
   output logic [255:0] o_tdata,
   output logic [31:0]  o_tstrb
);

   always_comb begin
      o_tdata = '0;
      for (int k = 0; k < 8; k++) begin
         o_tdata[k*32 +: 32] = {i_seq, i_beat, 8'(k)};
      end
      if (i_last && (i_len_rem != 5'd0)) begin
         o_tstrb = (32'd1 << i_len_rem) - 32'd1;
      end else begin
         o_tstrb = '1;
      end
   end

endmodule

// File: rtl/axis_pkt_gen.sv
// Synthetic NetFPGA-format AXI4-Stream packet source with configurable
// length, count, inter-packet gap and port metadata.
//
// state | meaning
// IDLE  | no run active, outputs quiet, waiting for start
// SEND  | driving beats of the current packet
// GAP   | idle cycles between packets (also the one-cycle lead-in after start)
module axis_pkt_gen
   import axis_pkt_gen_pkg::*;
#(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_MIN_LEN            = C_MIN_LEN_DEF
) (
   input  logic                              axi_aclk,
   input  logic                              axi_resetn,
   input  logic                              start,
   input  logic                              stop,
   input  logic [15:0]                       pkt_len,
   input  logic [31:0]                       pkt_count,
   input  logic [15:0]                       gap_cycles,
   input  logic [7:0]                        src_port,
   input  logic [7:0]                        dst_port,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast,
   output logic                              busy,
   output logic [31:0]                       pkts_sent
);

   state_t        r_state, w_next;
   logic [15:0]   r_len;
   logic [10:0]   r_last_beat;
   logic [31:0]   r_count;
   logic [15:0]   r_gap;
   logic [7:0]    r_src, r_dst;
   logic          r_stop_pending, r_lead;
   logic [15:0]   r_gap_cnt;
   logic [10:0]   r_beat;
   logic [15:0]   r_seq;
   logic [31:0]   r_pkts_sent;

   logic [15:0]   w_len_eff;
   logic          w_send, w_last, w_hs, w_eop, w_start, w_stop_req, w_run_done;
   logic [255:0]  w_pat_data;
   logic [31:0]   w_pat_strb;

   assign w_len_eff  = (pkt_len < 16'(C_MIN_LEN)) ? 16'(C_MIN_LEN) : pkt_len;
   assign w_send     = (r_state == ST_SEND);
   assign w_last     = w_send && (r_beat == r_last_beat);
   assign w_hs       = w_send && m_axis_tready;
   assign w_eop      = w_hs && w_last;
   assign w_start    = (r_state == ST_IDLE) && start;
   assign w_stop_req = r_stop_pending | stop;
   assign w_run_done = w_stop_req || ((r_count != 32'd0) && (r_pkts_sent + 32'd1 == r_count));

   axis_pkt_gen_pattern u_pattern (
      .i_seq     (r_seq),
      .i_beat    (r_beat[7:0]),
      .i_last    (w_last),
      .i_len_rem (r_len[4:0]),
      .o_tdata   (w_pat_data),
      .o_tstrb   (w_pat_strb)
   );

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // The lead-in GAP cycle after start cannot be cut short by stop, so a
   // start+stop pair still produces exactly one packet.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next = ST_GAP;
         end
         ST_SEND: begin
            if (w_eop) begin
               if (w_run_done)            w_next = ST_IDLE;
               else if (r_gap != 16'd0)   w_next = ST_GAP;
            end
         end
         ST_GAP: begin
            if (w_stop_req && !r_lead)    w_next = ST_IDLE;
            else if (r_gap_cnt == 16'd1)  w_next = ST_SEND;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_len          <= '0;
         r_last_beat    <= '0;
         r_count        <= '0;
         r_gap          <= '0;
         r_src          <= '0;
         r_dst          <= '0;
         r_stop_pending <= 1'b0;
         r_lead         <= 1'b0;
         r_gap_cnt      <= '0;
         r_beat         <= '0;
         r_seq          <= '0;
         r_pkts_sent    <= '0;
      end else if (w_start) begin
         r_len          <= w_len_eff;
         r_last_beat    <= last_beat_idx(w_len_eff);
         r_count        <= pkt_count;
         r_gap          <= gap_cycles;
         r_src          <= src_port;
         r_dst          <= dst_port;
         r_stop_pending <= stop;
         r_lead         <= 1'b1;
         r_gap_cnt      <= 16'd1;
         r_beat         <= '0;
         r_seq          <= '0;
         r_pkts_sent    <= '0;
      end else begin
         if ((r_state != ST_IDLE) && (w_next == ST_IDLE)) begin
            r_stop_pending <= 1'b0;
         end else if (stop && (r_state != ST_IDLE)) begin
            r_stop_pending <= 1'b1;
         end
         if (w_send) r_lead <= 1'b0;
         if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt - 16'd1;
         if (w_eop) begin
            r_gap_cnt   <= r_gap;
            r_beat      <= '0;
            r_seq       <= r_seq + 16'd1;
            r_pkts_sent <= r_pkts_sent + 32'd1;
         end else if (w_hs) begin
            r_beat      <= r_beat + 11'd1;
         end
      end
   end

   always_comb begin
      busy          = (r_state != ST_IDLE);
      m_axis_tvalid = w_send;
      m_axis_tlast  = w_last;
      m_axis_tdata  = w_send ? w_pat_data : '0;
      m_axis_tstrb  = w_send ? w_pat_strb : '0;
      m_axis_tuser  = '0;
      if (w_send) begin
         m_axis_tuser[LEN_LSB +: 16] = r_len;
         m_axis_tuser[SRC_LSB +: 8]  = r_src;
         m_axis_tuser[DST_LSB +: 8]  = r_dst;
      end
      pkts_sent     = r_pkts_sent;
   end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen: table of packet runs plus hand-written
// stall, stop, start+stop and reset sequences.
module tb_axis_pkt_gen;

   logic          axi_aclk = 1'b0;
   logic          axi_resetn;
   logic          start, stop;
   logic [15:0]   pkt_len;
   logic [31:0]   pkt_count;
   logic [15:0]   gap_cycles;
   logic [7:0]    src_port, dst_port;
   logic [255:0]  m_axis_tdata;
   logic [31:0]   m_axis_tstrb;
   logic [127:0]  m_axis_tuser;
   logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic          busy;
   logic [31:0]   pkts_sent;

   int total = 0;
   int bad   = 0;

   always #5 axi_aclk = ~axi_aclk;

   axis_pkt_gen dut (
      .axi_aclk      (axi_aclk),
      .axi_resetn    (axi_resetn),
      .start         (start),
      .stop          (stop),
      .pkt_len       (pkt_len),
      .pkt_count     (pkt_count),
      .gap_cycles    (gap_cycles),
      .src_port      (src_port),
      .dst_port      (dst_port),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tstrb  (m_axis_tstrb),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .busy          (busy),
      .pkts_sent     (pkts_sent)
   );

   typedef struct {
      logic [15:0] len;
      logic [31:0] cnt;
      logic [15:0] gap;
      logic [7:0]  sp;
      logic [7:0]  dp;
      int          nb;
      logic [31:0] lstrb;
      logic [15:0] l;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [255:0] exp_data(input int seq, input int beat);
      logic [255:0] d;
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = {16'(seq), 8'(beat), 8'(k)};
      return d;
   endfunction

   // Pulses start with the given configuration, checks the lead-in cycle, then
   // holds start high with junk configuration that a busy block must ignore.
   task automatic start_run(input logic [15:0] len, input logic [31:0] cnt, input logic [15:0] gap,
                            input logic [7:0] sp, input logic [7:0] dp, input bit stop_too);
      @(negedge axi_aclk);
      pkt_len = len; pkt_count = cnt; gap_cycles = gap; src_port = sp; dst_port = dp;
      start = 1'b1; stop = stop_too;
      @(negedge axi_aclk);
      chk("lead-in tvalid", 256'(m_axis_tvalid), 256'(0));
      chk("lead-in busy", 256'(busy), 256'(1));
      stop = 1'b0;
      pkt_len = 16'd300; pkt_count = 32'd7; gap_cycles = 16'd9; src_port = ~sp; dst_port = ~dp;
   endtask

   task automatic recv_pkt(input int seq, input int nb, input logic [31:0] lstrb, input logic [15:0] l,
                           input logic [7:0] sp, input logic [7:0] dp, input bit rnd,
                           input int stop_beat, output int idle);
      int b = 0;
      int guard = 0;
      idle = 0;
      while (b < nb && guard < 2000) begin
         @(negedge axi_aclk);
         guard++;
         start = 1'b0;
         m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stop_beat >= 0) stop = m_axis_tvalid && (b == stop_beat);
         if (m_axis_tvalid) begin
            chk($sformatf("tdata s%0d b%0d", seq, b), m_axis_tdata, exp_data(seq, b));
            chk($sformatf("tstrb s%0d b%0d", seq, b), 256'(m_axis_tstrb),
                256'((b == nb - 1) ? lstrb : 32'hFFFF_FFFF));
            chk($sformatf("tlast s%0d b%0d", seq, b), 256'(m_axis_tlast), 256'(b == nb - 1));
            chk($sformatf("tuser s%0d b%0d", seq, b), 256'(m_axis_tuser), 256'({96'd0, dp, sp, l}));
            if (m_axis_tready) b++;
         end else if (b > 0) begin
            chk($sformatf("tvalid drop s%0d b%0d", seq, b), 256'(0), 256'(1));
         end else begin
            idle++;
         end
      end
      if (guard >= 2000) begin
         total++; bad++;
         $display("FAIL timeout s%0d: got %0d beats expected %0d", seq, b, nb);
      end
      stop = 1'b0;
   endtask

   task automatic check_end(input string nm, input logic [31:0] exp_pkts);
      @(negedge axi_aclk);
      chk({nm, " busy"}, 256'(busy), 256'(0));
      chk({nm, " tvalid"}, 256'(m_axis_tvalid), 256'(0));
      chk({nm, " pkts_sent"}, 256'(pkts_sent), 256'(exp_pkts));
   endtask

   initial begin
      int idle;

      vecs[0] = '{len:16'd64,  cnt:32'd2, gap:16'd0, sp:8'h11, dp:8'h22, nb:2, lstrb:32'hFFFF_FFFF, l:16'd64};
      vecs[1] = '{len:16'd65,  cnt:32'd1, gap:16'd0, sp:8'h01, dp:8'h02, nb:3, lstrb:32'h0000_0001, l:16'd65};
      vecs[2] = '{len:16'd10,  cnt:32'd1, gap:16'd0, sp:8'hA5, dp:8'h5A, nb:2, lstrb:32'h0FFF_FFFF, l:16'd60};
      vecs[3] = '{len:16'd100, cnt:32'd2, gap:16'd3, sp:8'h40, dp:8'h80, nb:4, lstrb:32'h0000_000F, l:16'd100};
      vecs[4] = '{len:16'd61,  cnt:32'd1, gap:16'd0, sp:8'hFF, dp:8'h00, nb:2, lstrb:32'h1FFF_FFFF, l:16'd61};
      vecs[5] = '{len:16'd96,  cnt:32'd2, gap:16'd1, sp:8'h3C, dp:8'hC3, nb:3, lstrb:32'hFFFF_FFFF, l:16'd96};

      axi_resetn = 1'b0; start = 1'b0; stop = 1'b0; m_axis_tready = 1'b1;
      pkt_len = '0; pkt_count = '0; gap_cycles = '0; src_port = '0; dst_port = '0;
      repeat (3) @(negedge axi_aclk);
      chk("reset tvalid", 256'(m_axis_tvalid), 256'(0));
      chk("reset tlast", 256'(m_axis_tlast), 256'(0));
      chk("reset busy", 256'(busy), 256'(0));
      chk("reset pkts_sent", 256'(pkts_sent), 256'(0));
      chk("reset tdata", m_axis_tdata, 256'(0));
      chk("reset tstrb/tuser", 256'({m_axis_tstrb, m_axis_tuser}), 256'(0));
      axi_resetn = 1'b1;
      repeat (2) @(negedge axi_aclk);

      for (int v = 0; v < 6; v++) begin
         start_run(vecs[v].len, vecs[v].cnt, vecs[v].gap, vecs[v].sp, vecs[v].dp, 1'b0);
         for (int p = 0; p < int'(vecs[v].cnt); p++) begin
            recv_pkt(p, vecs[v].nb, vecs[v].lstrb, vecs[v].l, vecs[v].sp, vecs[v].dp, 1'b0, -1, idle);
            chk($sformatf("vec%0d idle before p%0d", v, p), 256'(idle),
                256'((p == 0) ? 0 : int'(vecs[v].gap)));
         end
         check_end($sformatf("vec%0d end", v), vecs[v].cnt);
      end

      // Random backpressure with a 5-cycle gap.
      start_run(16'd128, 32'd3, 16'd5, 8'h12, 8'h34, 1'b0);
      for (int p = 0; p < 3; p++) begin
         recv_pkt(p, 4, 32'hFFFF_FFFF, 16'd128, 8'h12, 8'h34, 1'b1, -1, idle);
         if (p > 0) chk($sformatf("stall gap p%0d", p), 256'(idle), 256'(5));
      end
      m_axis_tready = 1'b1;
      check_end("stall end", 32'd3);

      // Endless run stopped during the third packet.
      start_run(16'd128, 32'd0, 16'd2, 8'h77, 8'h88, 1'b0);
      for (int p = 0; p < 3; p++) begin
         recv_pkt(p, 4, 32'hFFFF_FFFF, 16'd128, 8'h77, 8'h88, 1'b0, (p == 2) ? 1 : -1, idle);
         if (p > 0) chk($sformatf("stop-run gap p%0d", p), 256'(idle), 256'(2));
      end
      check_end("stop end", 32'd3);
      repeat (4) @(negedge axi_aclk);
      chk("stop stays idle", 256'({busy, m_axis_tvalid}), 256'(0));

      // Fresh run after stop, then start coincident with stop.
      start_run(16'd64, 32'd1, 16'd0, 8'h05, 8'h06, 1'b0);
      recv_pkt(0, 2, 32'hFFFF_FFFF, 16'd64, 8'h05, 8'h06, 1'b0, -1, idle);
      check_end("restart end", 32'd1);
      start_run(16'd64, 32'd0, 16'd4, 8'h09, 8'h0A, 1'b1);
      recv_pkt(0, 2, 32'hFFFF_FFFF, 16'd64, 8'h09, 8'h0A, 1'b0, -1, idle);
      check_end("start+stop end", 32'd1);

      // Reset asserted on the second beat of a 4-beat packet.
      start_run(16'd128, 32'd1, 16'd0, 8'h21, 8'h43, 1'b0);
      @(negedge axi_aclk);
      start = 1'b0; m_axis_tready = 1'b1;
      chk("rst-seq beat0 tvalid", 256'(m_axis_tvalid), 256'(1));
      @(negedge axi_aclk);
      chk("rst-seq beat1 tdata", m_axis_tdata, exp_data(0, 1));
      axi_resetn = 1'b0;
      #1;
      chk("mid-reset tvalid/tlast", 256'({m_axis_tvalid, m_axis_tlast}), 256'(0));
      chk("mid-reset busy/pkts", 256'({busy, pkts_sent}), 256'(0));
      @(negedge axi_aclk);
      axi_resetn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge axi_aclk);
         chk($sformatf("post-reset quiet %0d", i), 256'({busy, m_axis_tvalid}), 256'(0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
